// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select for the shared memory port: data has priority, but fetch is
// forced through after STARVE_LIMIT consecutive data wins while it waits.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic arb_en,
  input  logic if_req,
  input  logic d_req,
  output logic winner
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;

  always_comb begin
    winner = PORT_D;
    if (if_req && (!d_req || (starve_cnt == LIMIT))) begin
      winner = PORT_IF;
    end
  end

  // Counts data wins only while fetch is actually left waiting; saturates.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (arb_en) begin
      if ((winner == PORT_IF) || !if_req) begin
        starve_cnt <= '0;
      end else if (starve_cnt != LIMIT) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data load/store,
// sequencing each granted access as ISSUE -> WAIT (MEM_LATENCY cycles) -> RESP.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  // Handshake: a requester raises req with stable addr/we/wdata and holds it
  // until its one-cycle ack; the request is sampled only in IDLE, and changes
  // after that sample have no effect on the access already in progress.

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LATENCY - 1);

  arb_state_t        state;
  arb_state_t        next_state;
  logic [3:0]        lat_cnt;
  logic              arb_en;
  logic              winner;
  logic              win_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  assign arb_en    = (state == IDLE) && (if_req || d_req);
  assign busy      = (state != IDLE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  mem_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .clk    (clk),
    .reset_n(reset_n),
    .arb_en (arb_en),
    .if_req (if_req),
    .d_req  (d_req),
    .winner (winner)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (arb_en) next_state = ISSUE;
      ISSUE:   next_state = WAIT;
      WAIT:    if (lat_cnt == 4'd0) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Command, latency and response registers; strobes default low every cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_q     <= PORT_IF;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      lat_cnt   <= 4'd0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_en) begin
            win_q   <= winner;
            addr_q  <= (winner == PORT_IF) ? if_addr : d_addr;
            we_q    <= (winner == PORT_D) && d_we;
            wdata_q <= (winner == PORT_D) ? d_wdata : '0;
            mem_en  <= 1'b1;
            mem_we  <= (winner == PORT_D) && d_we;
          end
        end
        ISSUE: begin
          lat_cnt <= LAT_LOAD;
        end
        WAIT: begin
          if (lat_cnt == 4'd0) begin
            if (!we_q) rsp_rdata <= mem_rdata;
            if_ack <= (win_q == PORT_IF);
            d_ack  <= (win_q == PORT_D);
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
